// File: rtl/fht_adc_loader_pkg.sv
// Shared types and helpers for the FHT frame loader.
// The state enum, the sample-format conversion and the default frame geometry.
package fht_loader_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_START,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } loader_state_t;

  localparam int A_BIT_DFLT = 8;
  localparam int BANK_SIZE  = 2 ** A_BIT_DFLT;
  localparam int FRAME_SIZE = 4 * BANK_SIZE;

  // The integer part lands in the top bits; the fraction is zero-filled.
  function automatic logic [63:0] f_adc_to_fixp(input logic [63:0] sample,
                                                input int          frac_bits);
    return sample << frac_bits;
  endfunction

endpackage

// File: rtl/fht_adc_loader_sat_counter.sv
// Saturating up-counter with synchronous clear; used to count dropped samples.
module fht_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fht_adc_loader.sv
// Frame loader feeding fht_top: spreads ADC samples row by row over four banks,
// starts the transform once a frame is written and drops samples while busy.
module fht_adc_loader
  import fht_loader_pkg::*;
#(
  parameter int ADC_WIDTH = 16,
  parameter int D_BIT     = 22,
  parameter int A_BIT     = 8,
  parameter int DROP_W    = 16
) (
  input  logic                        iCLK,
  input  logic                        iRESET,
  input  logic                        iADC_VALID,
  input  logic signed [ADC_WIDTH-1:0] iADC_DATA,
  input  logic                        iFHT_RDY,
  output logic [3:0]                  oWE,
  output logic [A_BIT-1:0]            oADDR_WR,
  output logic signed [D_BIT-1:0]     oDATA,
  output logic                        oSTART,
  output logic                        oBUSY,
  output logic                        oDROP,
  output logic [DROP_W-1:0]           oDROP_CNT
);

  localparam int FRAC_W = D_BIT - ADC_WIDTH;

  loader_state_t      state;
  logic [A_BIT+1:0]   frame_cnt;
  logic               drop_now;
  logic signed [D_BIT-1:0] fixp;

  assign drop_now = iADC_VALID && (state != ST_FILL);
  assign fixp     = D_BIT'(f_adc_to_fixp(64'(iADC_DATA), FRAC_W));

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state     <= ST_FILL;
      frame_cnt <= '0;
      oWE       <= '0;
      oADDR_WR  <= '0;
      oDATA     <= '0;
      oSTART    <= 1'b0;
      oBUSY     <= 1'b0;
      oDROP     <= 1'b0;
    end else begin
      oWE    <= '0;
      oSTART <= 1'b0;
      oDROP  <= drop_now;
      case (state)
        ST_FILL: begin
          if (iADC_VALID) begin
            oWE       <= 4'b0001 << frame_cnt[1:0];
            oADDR_WR  <= frame_cnt[A_BIT+1:2];
            oDATA     <= fixp;
            frame_cnt <= frame_cnt + 1'b1;
            // Last sample of the frame: the counter wraps and the write retires before oSTART.
            if (&frame_cnt) begin
              state <= ST_START;
              oBUSY <= 1'b1;
            end
          end
        end
        ST_START: begin
          oSTART <= 1'b1;
          state  <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (!iFHT_RDY) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (iFHT_RDY) begin
            state <= ST_FILL;
            oBUSY <= 1'b0;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  fht_sat_counter #(
    .W(DROP_W)
  ) u_drop_cnt (
    .clk  (iCLK),
    .clear(iRESET),
    .inc  (drop_now),
    .count(oDROP_CNT)
  );

endmodule

// File: tb/tb_fht_adc_loader.sv
// Randomised bench for fht_adc_loader (A_BIT=2) against a frame-level reference model;
// a second instance with a 3-bit drop counter exercises saturation.
module tb_fht_adc_loader;

  logic               clk = 1'b0;
  logic               rst;
  logic               adc_valid;
  logic signed [15:0] adc_data;
  logic               fht_rdy;

  logic [3:0]         we, sat_we;
  logic [1:0]         addr, sat_addr;
  logic [21:0]        data, sat_data;
  logic               start, sat_start, busy, sat_busy, drop, sat_drop;
  logic [15:0]        drop_cnt;
  logic [2:0]         sat_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_n, m_phase, n_start;
  bit          m_accept;
  logic [3:0]  e_we;
  logic [1:0]  e_addr;
  logic [21:0] e_data;
  bit          e_start, e_busy, e_drop;
  int          e_cnt, e_sat;
  int          rdy_hold, low_left;

  always #5 clk = ~clk;

  fht_adc_loader #(.ADC_WIDTH(16), .D_BIT(22), .A_BIT(2), .DROP_W(16)) u_dut (
    .iCLK(clk), .iRESET(rst), .iADC_VALID(adc_valid), .iADC_DATA(adc_data),
    .iFHT_RDY(fht_rdy), .oWE(we), .oADDR_WR(addr), .oDATA(data), .oSTART(start),
    .oBUSY(busy), .oDROP(drop), .oDROP_CNT(drop_cnt));

  fht_adc_loader #(.ADC_WIDTH(16), .D_BIT(22), .A_BIT(2), .DROP_W(3)) u_sat (
    .iCLK(clk), .iRESET(rst), .iADC_VALID(adc_valid), .iADC_DATA(adc_data),
    .iFHT_RDY(fht_rdy), .oWE(sat_we), .oADDR_WR(sat_addr), .oDATA(sat_data),
    .oSTART(sat_start), .oBUSY(sat_busy), .oDROP(sat_drop), .oDROP_CNT(sat_cnt));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_phase = 0; m_accept = 1;
    e_we = '0; e_addr = '0; e_data = '0;
    e_start = 0; e_busy = 0; e_drop = 0; e_cnt = 0; e_sat = 0;
    rdy_hold = 0; low_left = 0;
  endtask

  // Frame-level behaviour: 16 samples fill a frame, then the loader is busy until
  // the FHT has dropped and raised its ready again; every sample meanwhile is lost.
  task automatic model_cycle(input bit v, input logic [15:0] d, input bit rdy);
    e_we = '0; e_start = 0; e_drop = 0;
    if (m_accept) begin
      if (v) begin
        e_we   = 4'(1 << (m_n % 4));
        e_addr = 2'(m_n / 4);
        e_data = 22'(32'(d) * 64);
        m_n++;
        if (m_n == 16) begin
          m_n = 0; m_accept = 0; m_phase = 1;
        end
      end
    end else begin
      if (v) begin
        e_drop = 1;
        if (e_cnt < 65535) e_cnt++;
        if (e_sat < 7) e_sat++;
      end
      if (m_phase == 1) begin
        e_start = 1; m_phase = 2;
      end else if (m_phase == 2) begin
        if (!rdy) m_phase = 3;
      end else if (m_phase == 3) begin
        if (rdy) m_accept = 1;
      end
    end
    e_busy = !m_accept;
  endtask

  task automatic compare_all();
    check("we", we, e_we);
    check("addr", addr, e_addr);
    check("data", data, e_data);
    check("start", start, e_start);
    check("busy", busy, e_busy);
    check("drop", drop, e_drop);
    check("drop_cnt", drop_cnt, e_cnt);
    check("sat_drop", sat_drop, e_drop);
    check("sat_cnt", sat_cnt, e_sat);
  endtask

  // One clock of stimulus; the FHT stand-in pulls ready low for 50 cycles
  // beginning one cycle after it sees a start pulse.
  task automatic step(input bit v, input logic [15:0] d);
    bit r;
    if (rdy_hold > 0) begin
      r = 1; rdy_hold--;
    end else if (low_left > 0) begin
      r = 0; low_left--;
    end else begin
      r = 1;
    end
    adc_valid = v; adc_data = d; fht_rdy = r;
    model_cycle(v, d, r);
    @(posedge clk); #1;
    compare_all();
    if (start) n_start++;
    if (e_start) begin
      rdy_hold = 1; low_left = 50;
    end
  endtask

  task automatic do_reset();
    rst = 1; adc_valid = 1; adc_data = 16'h1234; fht_rdy = 1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    compare_all();
    check("rst_busy", busy, 0);
    rst = 0; adc_valid = 0;
  endtask

  initial begin
    rst = 1; adc_valid = 0; adc_data = '0; fht_rdy = 1;
    n_start = 0;
    do_reset();

    // Ordered fill, then valid held high across the whole handshake
    for (int n = 0; n < 16; n++) step(1, 16'(n));
    for (int i = 0; i < 60; i++) step(1, 16'($urandom));
    check("ordered_start_count", n_start, 1);
    check("handshake_drops", drop_cnt, 53);
    check("sat_hold", sat_cnt, 7);

    // Mid-frame reset: 7 samples written, then reset and stay idle
    do_reset();
    n_start = 0;
    for (int n = 0; n < 7; n++) step(1, 16'($urandom));
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 16'($urandom));
    check("no_start_after_reset", n_start, 0);

    // Sign/format corners at the head of a fresh frame
    step(1, 16'h8000);
    check("fmt_min", data, 22'h200000);
    check("fmt_min_bank", we, 4'b0001);
    step(1, 16'hFFFF);
    check("fmt_neg1", data, 22'h3FFFC0);

    // Random traffic across several frames and handshakes
    for (int i = 0; i < 400; i++) step(($urandom % 10) < 7, 16'($urandom));
    check("random_starts", n_start > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
